// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, oversampling default,
// and the 8N1 line/frame constants that the transmit side also relies on.
package uart_pkg;

    // Receiver FSM state encoding (plain constants so older tools accept them).
    localparam int         STATE_W   = 3;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    // Ticks per bit period unless a block overrides it.
    localparam int OVERSAMPLE_DEFAULT = 16;

    // 8N1 frame shape shared by receiver and transmitter.
    localparam int   FRAME_DATA_BITS = 8;
    localparam int   FRAME_STOP_BITS = 1;
    localparam logic LINE_IDLE       = 1'b1;  // idle and stop level
    localparam logic LINE_START      = 1'b0;  // start bit level

    // Depth of the metastability synchronizer on asynchronous line inputs.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIVISOR clocks.
// Never restarted by line activity, so receiver and transmitter can share it.
module uart_tick_gen #(
    parameter int DIVISOR = 27
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Tick on the last count of the period, then wrap to zero.
    always_comb begin
        tick    = (count_q == CNT_MAX);
        count_d = tick ? '0 : count_q + 1'b1;
    end

    // Divider counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the rx pin, validates the start bit at
// mid-bit, deserializes LSB-first data, checks the stop bit and hands the
// byte to the consumer over a valid/ready handshake. Framing errors and
// overruns are reported as single-cycle pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIVISOR    = 27,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = FRAME_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int                  SAMPLE_W  = $clog2(OVERSAMPLE);
    localparam int                  BIT_W     = $clog2(DATA_BITS);
    localparam logic [SAMPLE_W-1:0] HALF_LAST = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] FULL_LAST = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic tick;

    // Synchronizer chain; the last stage is the only view of the line used.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rx_s;

    // Receive FSM state.
    logic [STATE_W-1:0]   state_q,      state_d;
    logic [SAMPLE_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 deliver_q,    deliver_d;
    logic                 frame_err_q,  frame_err_d;

    // Output handshake state.
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 overrun_q,    overrun_d;

    uart_tick_gen #(
        .DIVISOR (DIVISOR)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Shift the raw pin into the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
        rx_s   = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer registers; reset to the idle line level so no false start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{LINE_IDLE}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // Frame FSM: advances only on oversample ticks.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        deliver_d    = 1'b0;
        frame_err_d  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (rx_s == LINE_START) begin
                        state_d      = START;
                        sample_cnt_d = '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit in; a short low is a glitch.
                    if (sample_cnt_q == HALF_LAST) begin
                        sample_cnt_d = '0;
                        if (rx_s != LINE_START) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    // Sample at mid-bit; LSB arrives first so shift in at the top.
                    if (sample_cnt_q == FULL_LAST) begin
                        sample_cnt_d = '0;
                        shift_d      = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (sample_cnt_q == FULL_LAST) begin
                        sample_cnt_d = '0;
                        if (rx_s == LINE_IDLE) begin
                            deliver_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            // Bad stop bit: drop the byte and wait out any break.
                            frame_err_d = 1'b1;
                            shift_d     = '0;
                            state_d     = WAIT_HIGH;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s == LINE_IDLE) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                end
            endcase
        end
    end

    // Frame FSM registers, including the deliver strobe and frame error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            deliver_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            deliver_q    <= deliver_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Output handshake: load on deliver if the slot is free or being drained
    // this very cycle, otherwise drop the new byte and flag an overrun.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (deliver_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // Output handshake registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames, expected bytes queued by the
// stimulus and popped by an independent monitor whenever a new byte appears.
module tb_uart_rx;

    localparam int DIV     = 4;
    localparam int OS      = 16;
    localparam int BIT_CLK = DIV * OS;                  // 64 clk per bit
    localparam int STOP_TICKS = OS / 2 + 9 * OS;         // ticks from start detect to stop sample

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx #(
        .DIVISOR    (DIV),
        .OVERSAMPLE (OS),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int rise_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, vlow_cnt = 0;
    int cur_len = 0, last_len = 0, rise_cyc = 0, fall_cyc = 0, rel_cyc = 0;
    logic pv = 1'b0, pacc = 1'b0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame starting now (caller is just past a posedge).
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        idle(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(BIT_CLK);
        end
        rx = stop_bit;
        idle(BIT_CLK);
    endtask

    // Monitor: pops the scoreboard whenever a new byte is presented.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
                pacc = 1'b0;
                cur_len = 0;
            end else begin
                if (frame_err) ferr_cnt++;
                if (overrun) ovr_cnt++;
                if (frame_err || overrun)
                    check_eq("err_pulses_exclusive", int'(frame_err & overrun), 0);
                if (!rx_valid) vlow_cnt++;
                if (rx_valid && (!pv || pacc)) begin
                    rise_cnt++;
                    rise_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rx_data", int'(rx_data), int'(e));
                    end
                end
                if (rx_valid) begin
                    cur_len++;
                end else if (pv) begin
                    last_len = cur_len;
                    cur_len = 0;
                end
                pv = rx_valid;
                pacc = rx_valid && rx_ready;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, f0, o0, v0, e, d;
        logic [7:0] b;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_rx_valid", int'(rx_valid), 0);
        check_eq("reset_rx_data", int'(rx_data), 0);
        check_eq("reset_frame_err", int'(frame_err), 0);
        check_eq("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
        rel_cyc = cyc;
        idle(20);

        // 1: clean 0xA5, latency and single-cycle valid.
        r0 = rise_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(40);
        check_eq("t1_rises", rise_cnt - r0, 1);
        check_range("t1_latency", rise_cyc - fall_cyc - 1, 611, 614);
        check_eq("t1_valid_len", last_len, 1);
        check_eq("t1_frame_err", ferr_cnt, 0);
        check_eq("t1_overrun", ovr_cnt, 0);

        // 2: 20-clk glitch is rejected, then 0x3C.
        r0 = rise_cnt;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(100);
        check_eq("t2_glitch_rises", rise_cnt - r0, 0);
        check_eq("t2_glitch_ferr", ferr_cnt, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(40);
        check_eq("t2_rises", rise_cnt - r0, 1);

        // 3: bad stop bit followed by a long break, then 0x3C.
        r0 = rise_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        idle(300);
        rx = 1'b1;
        idle(700);
        check_eq("t3_frame_err", ferr_cnt - f0, 1);
        check_eq("t3_bad_rises", rise_cnt - r0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(40);
        check_eq("t3_rises", rise_cnt - r0, 1);
        check_eq("t3_frame_err_after", ferr_cnt - f0, 1);

        // 4: overrun with rx_ready low, then drain.
        rx_ready = 1'b0;
        r0 = rise_cnt;
        o0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(40);
        check_eq("t4_overrun", ovr_cnt - o0, 1);
        check_eq("t4_rises", rise_cnt - r0, 1);
        check_eq("t4_valid_held", int'(rx_valid), 1);
        check_eq("t4_data_held", int'(rx_data), 8'h11);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check_eq("t4_valid_drained", int'(rx_valid), 0);
        check_eq("t4_data_kept", int'(rx_data), 8'h11);

        // 5: ready in exactly the deliver cycle replaces the byte seamlessly.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle(40);
        check_eq("t5_first_valid", int'(rx_valid), 1);
        r0 = rise_cnt;
        o0 = ovr_cnt;
        v0 = vlow_cnt;
        exp_q.push_back(8'h22);
        e = cyc + 3;
        while (((e - rel_cyc) % DIV) != 0) e++;
        d = e + STOP_TICKS * DIV;
        fork
            send_frame(8'h22, 1'b1);
            begin
                while (cyc < d) begin
                    @(posedge clk);
                    #1;
                end
                rx_ready = 1'b1;
                idle(1);
                rx_ready = 1'b0;
            end
        join
        idle(20);
        check_eq("t5_overrun", ovr_cnt - o0, 0);
        check_eq("t5_rises", rise_cnt - r0, 1);
        check_eq("t5_valid_never_low", vlow_cnt - v0, 0);
        check_eq("t5_valid", int'(rx_valid), 1);
        check_eq("t5_data", int'(rx_data), 8'h22);
        rx_ready = 1'b1;
        idle(2);

        // 6: reset during bit 4 aborts the frame, then 0x5A.
        r0 = rise_cnt;
        b = 8'h77;
        rx = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            idle(BIT_CLK);
        end
        rx = b[4];
        idle(BIT_CLK / 2);
        reset = 1'b1;
        rx = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t6_outputs_in_reset", int'({rx_valid, frame_err, overrun, rx_data}), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        rel_cyc = cyc;
        idle(100);
        check_eq("t6_no_partial", rise_cnt - r0, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(40);
        check_eq("t6_rises", rise_cnt - r0, 1);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        check_eq("total_frame_err", ferr_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side front end of the UART: oversamples the asynchronous serial line, validates the start bit, and deserializes 8N1 frames, LSB first.
- Presents each received byte on a valid/ready handshake to the downstream byte consumer.
- Flags framing errors and overruns as one-cycle pulses.
- Sits between the rx pin and the baud-rate sampling/shift stage's consumer logic; owns its own oversample tick.

Parameters:
- DIVISOR, 27, clk cycles per oversample tick (50 MHz / 115200 / 16); must be >= 2.
- OVERSAMPLE, 16, ticks per bit period; must be even and >= 4.
- DATA_BITS, 8, data bits per frame; range 5..8.

Ports:
- clk  input  1  single system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- rx  input  1  raw serial line, asynchronous to clk; idle high.
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts; transfer occurs when rx_valid & rx_ready on a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new frame completed while the previous byte was unaccepted.

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Synchronizer flops=1, state=IDLE, tick counter=0, sample_cnt=0, bit_cnt=0.
- rx passes through a 2-flop synchronizer; rx_s is the second flop. All decisions use rx_s only.
- Tick generator: free-running counter 0..DIVISOR-1; tick=1 for one clk when count==DIVISOR-1, then wraps to 0. It is never restarted by frame activity.
- Every state change and sample_cnt update happens only on tick cycles, except the output handshake, which runs every clk.
- State machine:
  - IDLE: on tick with rx_s=0 -> START, sample_cnt=0.
  - START: on tick, sample_cnt++.
    - When sample_cnt==OVERSAMPLE/2-1: rx_s=1 -> IDLE (glitch rejected, nothing reported); rx_s=0 -> DATA, with sample_cnt=0, bit_cnt=0.
  - DATA: on tick, sample_cnt++.
    - When sample_cnt==OVERSAMPLE-1: shift rx_s into the MSB of the shift register (LSB-first frame), bit_cnt++, sample_cnt=0.
    - After bit DATA_BITS-1 -> STOP.
  - STOP: on tick, sample_cnt++.
    - When sample_cnt==OVERSAMPLE-1: rx_s=1 -> deliver, then IDLE.
    - rx_s=0 -> frame_err pulse, shift register discarded, -> WAIT_HIGH.
  - WAIT_HIGH: on tick with rx_s=1 -> IDLE. A held-low line (break) never retriggers a start.
- Deliver happens on the clk after the stop-sample tick:
  - rx_valid=0, or rx_valid=1 with rx_ready=1 that cycle: load rx_data, rx_valid=1.
  - rx_valid=1 with rx_ready=0: overrun pulse; new byte dropped; rx_data and rx_valid unchanged.
- Handshake: rx_valid & rx_ready with no simultaneous deliver -> rx_valid=0 next clk; rx_data keeps its last value. rx_ready is ignored while rx_valid=0.
- Latency, rx pin falling edge to rx_valid rising:
  - 2 clk synchronizer + 0..DIVISOR-1 clk tick alignment + (OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE)*DIVISOR + 1 clk.
- Reset asserted mid-frame: immediate return to reset values; a partial byte is never delivered.
- frame_err and overrun never assert in the same cycle. Both are pulses and need no acknowledge.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: IDLE, START, DATA, STOP, WAIT_HIGH;
  - default OVERSAMPLE;
  - the 8N1 frame constants also used by the transmit side.
- One natural sub-module, uart_tick_gen (parameter DIVISOR; ports clk, reset, tick), reusable by the transmitter.
- The synchronizer and FSM stay inline in uart_rx.

Test Plan (DIVISOR=4, OVERSAMPLE=16 -> bit period 64 clk; rx_ready=1 unless stated):
- Send 0xA5, 8N1 -> rx_data=0xA5 and rx_valid high for exactly 1 clk. The rise occurs 611..614 clk after the rx falling edge; no error pulses.
- Drive an rx low glitch of 20 clk, then high -> no rx_valid, no frame_err, FSM back in IDLE. A following frame 0x3C is then received correctly.
- Send a frame with the stop bit 0, then hold rx low 300 clk, then high, then send 0x3C:
  - frame_err pulses once and no rx_valid for the bad frame;
  - no start is retriggered during the low hold;
  - then rx_data=0x3C.
- rx_ready=0; send 0x11 then 0x22 back-to-back:
  - rx_valid=1 with rx_data=0x11 throughout; overrun pulses once at the 0x22 stop sample;
  - then raise rx_ready for 1 clk -> rx_valid=0 next clk, rx_data remains 0x11.
- rx_ready=0; send 0x11; assert rx_ready in exactly the deliver cycle of the next frame 0x22 -> no overrun, rx_valid stays 1, rx_data=0x22.
- Assert reset for 3 clk during bit 4 of a frame:
  - all outputs are 0 within the reset window, with no rx_valid for that frame;
  - after release, line idle for 100 clk, then 0x5A is received correctly.
